// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One operation takes 35 cycles from start to the md_done pulse: PREP, 32 ITER steps, FIX.
module mult_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] md_reg_1,
   input  logic [31:0] md_reg_2,
   input  logic [1:0]  md_op,
   input  logic        md_start,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wr_data,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

   state_t      state, next_state;
   logic [31:0] a_reg, b_reg;
   logic [1:0]  op_reg;
   logic [5:0]  cnt;
   logic [63:0] acc;
   logic [63:0] mcand;
   logic [31:0] opb_abs;
   logic        neg_q, neg_r;

   logic        is_div, is_signed;
   logic [31:0] abs_a, abs_b;
   logic [32:0] div_shifted;
   logic [33:0] div_diff;
   logic [31:0] rem_new;
   logic [63:0] acc_step;
   logic [63:0] prod_fixed;
   logic [31:0] quot_fixed, rem_fixed;
   logic [31:0] res_hi, res_lo;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (md_start) next_state = PREP;
         PREP: next_state = ITER;
         ITER: if (cnt == 6'd31) next_state = FIX;
         FIX:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      md_busy = (state != IDLE);
   end

   // Operands are latched raw; magnitudes and result signs are derived during PREP.
   always_comb begin
      is_div    = op_reg[1];
      is_signed = ~op_reg[0];
      abs_a     = (is_signed && a_reg[31]) ? (32'd0 - a_reg) : a_reg;
      abs_b     = (is_signed && b_reg[31]) ? (32'd0 - b_reg) : b_reg;
   end

   // Divide keeps remainder in acc[63:32] and shifts the dividend/quotient through acc[31:0].
   always_comb begin
      div_shifted = acc[63:31];
      div_diff    = {1'b0, div_shifted} - {2'b00, opb_abs};
      rem_new     = div_diff[33] ? div_shifted[31:0] : div_diff[31:0];
      if (is_div)
         acc_step = {rem_new, acc[30:0], ~div_diff[33]};
      else
         acc_step = acc + (opb_abs[0] ? mcand : 64'd0);
   end

   always_comb begin
      prod_fixed = neg_q ? (64'd0 - acc) : acc;
      quot_fixed = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
      rem_fixed  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
      if (!is_div) begin
         res_hi = prod_fixed[63:32];
         res_lo = prod_fixed[31:0];
      end else if (b_reg == 32'd0) begin
         res_hi = a_reg;
         res_lo = 32'hFFFF_FFFF;
      end else begin
         res_hi = rem_fixed;
         res_lo = quot_fixed;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         op_reg  <= '0;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         opb_abs <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (md_start) begin
               a_reg  <= md_reg_1;
               b_reg  <= md_reg_2;
               op_reg <= md_op;
            end
            PREP: begin
               opb_abs <= abs_b;
               mcand   <= {32'd0, abs_a};
               acc     <= is_div ? {32'd0, abs_a} : 64'd0;
               neg_q   <= is_signed & (a_reg[31] ^ b_reg[31]);
               neg_r   <= is_signed & a_reg[31];
               cnt     <= '0;
            end
            ITER: begin
               acc <= acc_step;
               cnt <= cnt + 6'd1;
               if (!is_div) begin
                  mcand   <= {mcand[62:0], 1'b0};
                  opb_abs <= {1'b0, opb_abs[31:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // HI/LO accept MTHI/MTLO only when idle; the FIX exit edge writes the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi      <= '0;
         lo      <= '0;
         md_done <= 1'b0;
      end else begin
         md_done <= (state == FIX);
         if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE) begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
         end
      end
   end

endmodule
